// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with one write port and two
// registered read ports. A post-reset sequencer zeroes every entry before
// Ready rises. Optional same-cycle write-to-read forwarding is enabled by
// defining the macro REGFILE_BYPASS_EN; the default build has no forwarding.
module regfile_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic                  ReadEn1,
    input  logic                  ReadEn2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    output logic                  Ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Pointer is one bit wider than an address so the terminal compare never wraps.
    localparam logic [ADDR_WIDTH:0] LAST_PTR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH + 1)'(1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            state_r;
    logic [ADDR_WIDTH:0]   clear_ptr_r;
    logic                  ready_r;
    logic [DATA_WIDTH-1:0] read_data1_r;
    logic [DATA_WIDTH-1:0] read_data2_r;
    logic [DATA_WIDTH-1:0] regs_r [DEPTH];

    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic                  rd1_zero_s;
    logic                  rd2_zero_s;
    logic                  wr_zero_s;
    logic                  bypass1_s;
    logic                  bypass2_s;
    logic [DATA_WIDTH-1:0] rd1_next_s;
    logic [DATA_WIDTH-1:0] rd2_next_s;

    // Detect accesses to the hard-wired zero entry (only when ZERO_REG is set).
    always_comb begin
        rd1_zero_s = 1'b0;
        rd2_zero_s = 1'b0;
        wr_zero_s  = 1'b0;
        if (ZERO_REG != 0) begin
            rd1_zero_s = (ReadRegister1 == {ADDR_WIDTH{1'b0}});
            rd2_zero_s = (ReadRegister2 == {ADDR_WIDTH{1'b0}});
            wr_zero_s  = (WriteRegister == {ADDR_WIDTH{1'b0}});
        end else begin
            rd1_zero_s = 1'b0;
            rd2_zero_s = 1'b0;
            wr_zero_s  = 1'b0;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward a same-cycle write to a read port addressing the same entry.
    always_comb begin
        bypass1_s = RegWrite && ReadEn1 && (ReadRegister1 == WriteRegister);
        bypass2_s = RegWrite && ReadEn2 && (ReadRegister2 == WriteRegister);
    end
`else
    // No forwarding: reads always see the contents from before this edge's write.
    always_comb begin
        bypass1_s = 1'b0;
        bypass2_s = 1'b0;
    end
`endif

    // Select the value each read port would capture at the next edge.
    always_comb begin
        rd1_next_s = regs_r[ReadRegister1];
        rd2_next_s = regs_r[ReadRegister2];
        if (rd1_zero_s) begin
            rd1_next_s = {DATA_WIDTH{1'b0}};
        end else if (bypass1_s) begin
            rd1_next_s = WriteData;
        end else begin
            rd1_next_s = regs_r[ReadRegister1];
        end
        if (rd2_zero_s) begin
            rd2_next_s = {DATA_WIDTH{1'b0}};
        end else if (bypass2_s) begin
            rd2_next_s = WriteData;
        end else begin
            rd2_next_s = regs_r[ReadRegister2];
        end
    end

    // Single storage write port: clear sequencer in CLEAR, user writes in READY.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = WriteRegister;
        mem_wdata_s = WriteData;
        if (Rst) begin
            mem_we_s = 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = clear_ptr_r[ADDR_WIDTH-1:0];
                    mem_wdata_s = {DATA_WIDTH{1'b0}};
                end
                ST_READY: begin
                    mem_we_s = RegWrite && !wr_zero_s;
                end
                default: begin
                    mem_we_s = 1'b0;
                end
            endcase
        end
    end

    // Register array update; storage itself is not reset, the sequencer clears it.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            regs_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Control state, clear pointer, Ready flag and registered read outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r      <= ST_CLEAR;
            clear_ptr_r  <= {(ADDR_WIDTH + 1){1'b0}};
            ready_r      <= 1'b0;
            read_data1_r <= {DATA_WIDTH{1'b0}};
            read_data2_r <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    read_data1_r <= {DATA_WIDTH{1'b0}};
                    read_data2_r <= {DATA_WIDTH{1'b0}};
                    clear_ptr_r  <= clear_ptr_r + PTR_ONE;
                    if (clear_ptr_r == LAST_PTR) begin
                        state_r <= ST_READY;
                        ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_CLEAR;
                        ready_r <= 1'b0;
                    end
                end
                ST_READY: begin
                    ready_r <= 1'b1;
                    if (ReadEn1) begin
                        read_data1_r <= rd1_next_s;
                    end
                    if (ReadEn2) begin
                        read_data2_r <= rd2_next_s;
                    end
                end
                default: begin
                    state_r      <= ST_CLEAR;
                    clear_ptr_r  <= {(ADDR_WIDTH + 1){1'b0}};
                    ready_r      <= 1'b0;
                    read_data1_r <= {DATA_WIDTH{1'b0}};
                    read_data2_r <= {DATA_WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign ReadData1 = read_data1_r;
    assign ReadData2 = read_data2_r;
    assign Ready     = ready_r;

endmodule
